// File: rtl/seven_seg_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_scanner
//  Description : Converts a 14-bit binary value into four BCD digits with a
//                sequential shift-add-3 (double-dabble) engine, latches the
//                result into a display register and time-multiplexes the
//                digits towards a 7-segment digit decoder.
//  Ports       : clk      - system clock, rising edge
//                rst      - asynchronous active-high reset
//                value_in - binary value, sampled on an accepted load
//                load     - conversion request (pulse or level)
//                busy     - conversion in progress
//                done     - one-cycle pulse after the display register updates
//                digit    - digit code (0-9, 5'h1F = error)
//                exp      - digit position (0 = ones .. 3 = thousands)
//  Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scanner #(
    parameter int REFRESH_DIV = 50000,
    parameter int DIV_W       = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] value_in,
    input  logic        load,
    output logic        busy,
    output logic        done,
    output logic [4:0]  digit,
    output logic [2:0]  exp
);

    localparam logic [13:0]      c_max_value = 14'd9999;
    localparam logic [3:0]       c_last_step = 4'd13;
    localparam logic [DIV_W-1:0] c_div_last  = DIV_W'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_COMMIT  = 2'd2
    } state_t;

    state_t      r_state, w_state_next;
    logic [13:0] r_bin, w_bin_next;
    logic [15:0] r_bcd, w_bcd_next;
    logic [3:0]  r_step, w_step_next;
    logic        r_pend_err, w_pend_err_next;
    logic        r_busy, w_busy_next;
    logic        r_done, w_done_next;
    logic [15:0] r_disp, w_disp_next;
    logic        r_err, w_err_next;
    logic [15:0] w_bcd_adj;

    // Add-3 correction on every BCD nibble, applied before the shift.
    for (genvar i = 0; i < 4; i++) begin : g_adj
        assign w_bcd_adj[4*i +: 4] = (r_bcd[4*i +: 4] >= 4'd5) ?
                                     (r_bcd[4*i +: 4] + 4'd3) : r_bcd[4*i +: 4];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_bin      <= '0;
            r_bcd      <= '0;
            r_step     <= '0;
            r_pend_err <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_disp     <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_bin      <= w_bin_next;
            r_bcd      <= w_bcd_next;
            r_step     <= w_step_next;
            r_pend_err <= w_pend_err_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
            r_disp     <= w_disp_next;
            r_err      <= w_err_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_bin_next      = r_bin;
        w_bcd_next      = r_bcd;
        w_step_next     = r_step;
        w_pend_err_next = r_pend_err;
        w_busy_next     = r_busy;
        w_done_next     = 1'b0;
        w_disp_next     = r_disp;
        w_err_next      = r_err;
        case (r_state)
            S_IDLE: begin
                if (load) begin
                    w_busy_next = 1'b1;
                    if (value_in <= c_max_value) begin
                        w_bin_next      = value_in;
                        w_bcd_next      = '0;
                        w_step_next     = '0;
                        w_pend_err_next = 1'b0;
                        w_state_next    = S_CONVERT;
                    end else begin
                        // Out-of-range values skip the engine entirely.
                        w_pend_err_next = 1'b1;
                        w_state_next    = S_COMMIT;
                    end
                end
            end
            S_CONVERT: begin
                {w_bcd_next, w_bin_next} = {w_bcd_adj[14:0], r_bin, 1'b0};
                w_step_next = r_step + 4'd1;
                if (r_step == c_last_step) begin
                    w_state_next = S_COMMIT;
                end
            end
            S_COMMIT: begin
                if (r_pend_err) begin
                    w_err_next = 1'b1;
                end else begin
                    w_disp_next = r_bcd;
                    w_err_next  = 1'b0;
                end
                w_pend_err_next = 1'b0;
                w_done_next     = 1'b1;
                w_busy_next     = 1'b0;
                w_state_next    = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
                w_busy_next  = 1'b0;
            end
        endcase
    end

    // Free-running refresh scanner.
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_sel, w_sel_next;
    logic [4:0]       r_digit, w_digit_next;
    logic [2:0]       r_exp;
    logic             w_div_wrap;

    assign w_div_wrap = (r_div == c_div_last);
    assign w_sel_next = w_div_wrap ? (r_sel + 2'd1) : r_sel;

    // Output registers track the new select value so digit and exp move
    // together on the same edge as the select itself.
    always_comb begin
        w_digit_next = {1'b0, r_disp[{w_sel_next, 2'b00} +: 4]};
        if (r_err) begin
            w_digit_next = 5'h1F;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div   <= '0;
            r_sel   <= '0;
            r_digit <= '0;
            r_exp   <= '0;
        end else begin
            r_div   <= w_div_wrap ? '0 : (r_div + 1'b1);
            r_sel   <= w_sel_next;
            r_digit <= w_digit_next;
            r_exp   <= {1'b0, w_sel_next};
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign digit = r_digit;
    assign exp   = r_exp;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seven_seg_scanner
//  Description : Self-checking bench for seven_seg_scanner. A decimal model
//                of the displayed value and a cycle count since reset give
//                the expected scanner outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scanner;

    localparam int RDIV = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] value_in;
    logic        load;
    logic        busy;
    logic        done;
    logic [4:0]  digit;
    logic [2:0]  exp;

    always #5 clk = ~clk;

    seven_seg_scanner #(
        .REFRESH_DIV (RDIV),
        .DIV_W       (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .value_in (value_in),
        .load     (load),
        .busy     (busy),
        .done     (done),
        .digit    (digit),
        .exp      (exp)
    );

    int n_vec = 0;
    int n_bad = 0;
    int model_val = 0;
    bit model_err = 1'b0;
    int cyc;

    // Rising edges since the last reset.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] model_digit(input int pos);
        int d;
        if (model_err) return 32'h1F;
        d = model_val;
        for (int i = 0; i < pos; i++) d = d / 10;
        return 32'(d % 10);
    endfunction

    task automatic scan_check(input string tag);
        int pos;
        for (int k = 0; k < 4 * RDIV + 2; k++) begin
            @(negedge clk);
            pos = (cyc / RDIV) % 4;
            check({tag, "_exp"}, 32'(exp), 32'(pos));
            check({tag, "_digit"}, 32'(digit), model_digit(pos));
        end
    endtask

    task automatic apply_model(input int v);
        if (v > 9999) model_err = 1'b1;
        else begin
            model_err = 1'b0;
            model_val = v;
        end
    endtask

    // Issue one load of v, optionally a second load at observation index
    // intr_at (accepted or not per intr_ok), optionally a reset at rst_at.
    task automatic do_convert(input string tag, input int v, input int intr_at,
                              input int intr_v, input bit intr_ok, input int rst_at);
        int busy_n, done_n, done_at, ovl;
        bit aborted;
        busy_n = 0; done_n = 0; done_at = -1; ovl = 0; aborted = 1'b0;
        @(negedge clk);
        value_in = v[13:0];
        load     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) @(negedge clk);
            if (busy === 1'b1) busy_n++;
            if (done === 1'b1) begin
                done_n++;
                if (done_at < 0) done_at = k;
            end
            if (busy === 1'b1 && done === 1'b1) ovl++;
            if (k == intr_at) begin
                value_in = intr_v[13:0];
                load     = 1'b1;
            end
            if (intr_at >= 0 && k == intr_at + 1) load = 1'b0;
            if (k == rst_at) begin
                rst = 1'b1;
                #1;
                check({tag, "_rst_busy"}, 32'(busy), 32'd0);
                check({tag, "_rst_done"}, 32'(done), 32'd0);
                check({tag, "_rst_digit"}, 32'(digit), 32'd0);
                check({tag, "_rst_exp"}, 32'(exp), 32'd0);
                @(negedge clk);
                rst = 1'b0;
                aborted = 1'b1;
            end
        end
        check({tag, "_overlap"}, 32'(ovl), 32'd0);
        if (aborted) begin
            check({tag, "_done_cnt"}, 32'(done_n), 32'd0);
            model_val = 0;
            model_err = 1'b0;
        end else begin
            check({tag, "_done_cnt"}, 32'(done_n), intr_ok ? 32'd2 : 32'd1);
            check({tag, "_done_at"}, 32'(done_at), (v > 9999) ? 32'd1 : 32'd15);
            if (intr_at < 0)
                check({tag, "_busy_len"}, 32'(busy_n), (v > 9999) ? 32'd1 : 32'd15);
            apply_model(v);
            if (intr_ok) apply_model(intr_v);
        end
        scan_check(tag);
    endtask

    initial begin
        int v;
        rst      = 1'b1;
        load     = 1'b0;
        value_in = '0;
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_digit", 32'(digit), 32'd0);
        check("reset_exp", 32'(exp), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        scan_check("idle_scan");

        do_convert("v1234", 1234, -1, 0, 1'b0, -1);
        do_convert("v9999", 9999, -1, 0, 1'b0, -1);
        do_convert("v0", 0, -1, 0, 1'b0, -1);
        do_convert("v10000", 10000, -1, 0, 1'b0, -1);
        do_convert("v57", 57, -1, 0, 1'b0, -1);
        do_convert("busy_load", 1234, 4, 8888, 1'b0, -1);
        do_convert("done_load", 42, 15, 7305, 1'b1, -1);
        do_convert("err_max", 16383, -1, 0, 1'b0, -1);
        do_convert("mid_rst", 4321, -1, 0, 1'b0, 7);

        for (int n = 0; n < 10; n++) begin
            if ($urandom_range(0, 3) == 0) v = int'($urandom_range(10000, 16383));
            else                           v = int'($urandom_range(0, 9999));
            do_convert("rand", v, -1, 0, 1'b0, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
